// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT     = 2;

  typedef logic [15:0] len_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four LSB-first bytes into a 32-bit word and emits a registered
// one-cycle strobe in the cycle after the fourth byte is accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_last
);

  localparam logic [1:0] LastLane = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_reg;
  logic [23:0] sr_reg;
  logic [31:0] word_reg;
  logic        valid_reg;

  assign word_last  = en & (lane_reg == LastLane);
  assign word       = word_reg;
  assign word_valid = valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_reg  <= '0;
      sr_reg    <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= word_last;
      if (clear) begin
        lane_reg <= '0;
      end else if (en) begin
        lane_reg <= lane_reg + 2'd1;
        // Newest byte enters at the top so b0 ends up in the low lane.
        sr_reg   <= {byte_in, sr_reg[23:8]};
        if (word_last) begin
          word_reg <= {byte_in, sr_reg};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame parser for the boot image: length header, data words, XOR checksum.
// Holds the core in reset until a checksum-valid image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int NumInst = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int   IdxW   = $clog2(NumInst + 1);
  localparam len_t MaxLen = len_t'(NumInst);

  state_t          state_reg, state_next;
  len_t            len_reg;
  logic [7:0]      len_lo_reg;
  logic [IdxW-1:0] idx_reg;
  logic [7:0]      xor_reg;
  logic [31:0]     addr_reg;

  logic xfer, begin_load, data_en, word_last, last_word;
  len_t count, idx_ext;

  assign byte_ready = (state_reg == LEN0) || (state_reg == LEN1) ||
                      (state_reg == DATA) || (state_reg == CSUM);
  assign core_rst   = (state_reg != DONE);
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERR);

  assign xfer       = byte_valid & byte_ready;
  assign begin_load = start & ((state_reg == IDLE) || (state_reg == DONE) ||
                               (state_reg == ERR));
  assign data_en    = xfer & (state_reg == DATA);
  assign count      = {byte_in, len_lo_reg};
  assign idx_ext    = len_t'(idx_reg);
  assign last_word  = ((idx_ext + 16'd1) == len_reg);
  assign imem_addr  = addr_reg;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (begin_load),
    .en         (data_en),
    .byte_in    (byte_in),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .word_last  (word_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: if (start) state_next = LEN0;
      LEN0:            if (xfer) state_next = LEN1;
      LEN1: begin
        if (xfer) begin
          if (count == '0)         state_next = CSUM;
          else if (count > MaxLen) state_next = ERR;
          else                     state_next = DATA;
        end
      end
      DATA:            if (word_last && last_word) state_next = CSUM;
      CSUM:            if (xfer) state_next = (byte_in == xor_reg) ? DONE : ERR;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      len_lo_reg <= '0;
      idx_reg    <= '0;
      xor_reg    <= '0;
      addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (begin_load) begin
        idx_reg <= '0;
        xor_reg <= '0;
      end else if (xfer) begin
        xor_reg <= xor_reg ^ byte_in;
        if (state_reg == LEN0) len_lo_reg <= byte_in;
        if (state_reg == LEN1) len_reg    <= count;
        // Address is latched alongside the word so it is valid with imem_we.
        if (word_last) begin
          addr_reg <= 32'(idx_reg) << WORD_SHIFT;
          idx_reg  <= idx_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame-level bench for imem_loader with a per-cycle compare
// against expectations derived from the frame contents.
module tb_imem_loader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, imem_we, core_rst, done, error;
  logic [31:0] imem_addr, imem_wdata;

  imem_loader #(.NumInst(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gap_pct = 0;
  bit armed = 1'b0;
  bit m_loading = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] last_addr = '0, last_data = '0;
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] log_addr[$], log_data[$];
  int          log_cyc[$];
  logic [7:0]  fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model state.
  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        chk("rst_core_rst", core_rst, 1);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
      end else begin
        chk("byte_ready", byte_ready, m_loading);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("core_rst", core_rst, !m_done);
        if (imem_we) begin
          log_addr.push_back(imem_addr);
          log_data.push_back(imem_wdata);
          log_cyc.push_back(cyc);
          if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: addr %h data %h (cycle %0d)", imem_addr, imem_wdata, cyc);
          end else begin
            chk("wr_addr", imem_addr, exp_addr_q[0]);
            chk("wr_data", imem_wdata, exp_data_q[0]);
            last_addr = exp_addr_q.pop_front();
            last_data = exp_data_q.pop_front();
          end
        end else begin
          chk("hold_addr", imem_addr, last_addr);
          chk("hold_wdata", imem_wdata, last_data);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    m_loading = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
    last_addr = '0;
    last_data = '0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_core_rst", core_rst, 1);
    chk("reset_byte_ready", byte_ready, 0);
    chk("reset_we", imem_we, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_loading = 1'b1;
    m_done = 1'b0;
    m_err = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic build_rand(input int len, input bit good);
    logic [7:0] x;
    fr.delete();
    fr.push_back(len[7:0]);
    fr.push_back(len[15:8]);
    for (int i = 0; i < 4 * len; i++) fr.push_back(8'($urandom));
    x = 8'h00;
    foreach (fr[i]) x ^= fr[i];
    if (!good) x ^= 8'($urandom_range(1, 255));
    fr.push_back(x);
  endtask

  task automatic build_two_word(input logic [7:0] csum);
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    fr.push_back(csum);
  endtask

  // Drives up to max_bytes of fr, updating the expected writes and outcome.
  task automatic send(input int max_bytes);
    int len, tries;
    bit ok, len_ok;
    logic [7:0] run_x;
    len = int'({fr[1], fr[0]});
    len_ok = (len <= N);
    run_x = 8'h00;
    for (int k = 0; k < fr.size() && k < max_bytes; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
        start = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      byte_valid = 1'b1;
      byte_in = fr[k];
      ok = 1'b0;
      tries = 0;
      while (!ok) begin
        @(negedge clk);
        ok = byte_ready;
        @(posedge clk);
        #1;
        if (!ok) begin
          tries++;
          if (tries > 20) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: byte %0d never accepted", k);
            byte_valid = 1'b0;
            return;
          end
        end
      end
      if (k == 1 && !len_ok) begin
        m_loading = 1'b0;
        m_err = 1'b1;
        break;
      end
      if (k >= 2 && k < 2 + 4 * len && ((k - 2) % 4) == 3) begin
        exp_addr_q.push_back(32'(((k - 2) / 4) * 4));
        exp_data_q.push_back({fr[k], fr[k-1], fr[k-2], fr[k-3]});
      end
      if (k == 2 + 4 * len) begin
        m_loading = 1'b0;
        if (fr[k] == run_x) m_done = 1'b1;
        else                m_err = 1'b1;
      end
      run_x ^= fr[k];
    end
    byte_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", exp_addr_q.size(), 0);
  endtask

  task automatic chk_two_word_log();
    chk("n_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("w0_addr", log_addr[0], 32'h0);
      chk("w0_data", log_data[0], 32'h00500013);
      chk("w1_addr", log_addr[1], 32'h4);
      chk("w1_data", log_data[1], 32'h002080B3);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    armed = 1'b1;
    do_reset();

    // Two-word image, back-to-back stream.
    gap_pct = 0;
    do_start();
    chk("len0_ready", byte_ready, 1);
    build_two_word(8'h52);
    send(1000);
    settle();
    chk_two_word_log();
    if (log_cyc.size() == 2) chk("we_spacing", log_cyc[1] - log_cyc[0], 4);
    chk("two_word_done", done, 1);
    chk("two_word_core_rst", core_rst, 0);

    // Zero-length frame.
    do_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send(1000);
    settle();
    chk("zero_len_writes", log_addr.size(), 0);
    chk("zero_len_done", done, 1);

    // Length overflow: 33 words.
    do_start();
    build_rand(33, 1'b1);
    send(1000);
    settle();
    chk("ovf_writes", log_addr.size(), 0);
    chk("ovf_error", error, 1);
    chk("ovf_ready", byte_ready, 0);
    chk("ovf_core_rst", core_rst, 1);

    // Bad checksum, then recovery with a good frame.
    do_start();
    build_two_word(8'h00);
    send(1000);
    settle();
    chk_two_word_log();
    chk("badcs_error", error, 1);
    chk("badcs_core_rst", core_rst, 1);
    do_start();
    build_two_word(8'h52);
    send(1000);
    settle();
    chk("recover_done", done, 1);

    // Reset after six transfers, then a full load.
    do_start();
    build_two_word(8'h52);
    send(6);
    repeat (2) @(posedge clk);
    #1;
    chk("partial_writes", log_addr.size(), 1);
    do_reset();
    do_start();
    send(1000);
    settle();
    chk_two_word_log();
    chk("after_rst_done", done, 1);

    // Same image with random valid gaps and stray start pulses.
    gap_pct = 40;
    do_start();
    build_two_word(8'h52);
    send(1000);
    settle();
    chk_two_word_log();
    chk("gaps_done", done, 1);

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 40) : $urandom_range(0, N);
      gap_pct = $urandom_range(0, 50);
      build_rand(len, $urandom_range(0, 4) != 0);
      do_start();
      send(1000);
      settle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
